pipelined_cla_adder: RTL and testbench
======================================

// Module: pipelined_cla_adder
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor. It succeeds the fixed 64-bit combinational CLA.
//  WIDTH is split into STAGES equal segments. Each segment is a CLA built from 4-bit lookahead groups,
//  and the carry is registered between segments. A valid/ready handshake on input and output
//  allows back-pressure from the consumer. It sits between operand sources and result consumers in the datapath.
// PARAMETERS
//  WIDTH   64  operand/result width; multiple of 4*STAGES
//  STAGES  4   pipeline stages = segments (1..WIDTH/4); latency in cycles
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat offered
//  in_ready   out  1      block accepts beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in (ignored when in_sub=1)
//  in_sub     in   1      0: A+B+cin; 1: A-B (A + ~B + 1)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  sum/difference, mod 2^WIDTH
//  out_cout   out  1      carry out of MSB (for subtract: 1 = no borrow)
//  out_ovf    out  1      signed overflow: carry into MSB XOR carry out of MSB
//  out_zero   out  1      out_sum == 0
// BEHAVIOUR
//  - Reset (async assert, sync deassert at source): all stage valid bits = 0, out_valid = 0.
//    out_sum, out_cout, out_ovf and out_zero = 0. Pipeline data registers are cleared.
//  - Transfer on input when in_valid & in_ready; on output when out_valid & out_ready.
//  - Stage k (0..STAGES-1) holds a valid bit, the registered carry into segment k+1, and the
//    accumulated low sum bits. It also holds the still-unused operand segments and the sub flag.
//  - Segment k adds bits [(k+1)*SEG-1 : k*SEG], where SEG = WIDTH/STAGES. B is inverted when sub=1.
//    The carry-in is in_cin, or 1 when sub=1.
//  - Latency: a beat accepted at edge n gives out_valid=1 after edge n+STAGES-1, provided there is no stall.
//    With STAGES=1 the result is registered once (latency 1).
//  - Throughput: 1 beat/cycle when out_ready is held high.
//  - Stall rule: stage k advances iff stage k+1 is empty or is advancing. The last stage advances iff out_ready.
//    in_ready = !valid[0] | advance[0]. It is combinational from out_ready through the chain and never depends on in_valid.
//  - A stalled stage holds its data and valid bit unchanged. No beat is dropped or duplicated.
//  - Bubbles collapse: an empty stage accepts from upstream even while downstream stalls.
//  - Full pipeline with out_ready=0: in_ready=0. When out_ready rises, in_ready rises in the same cycle.
//  - Simultaneous input and output transfer on a full pipeline is legal and keeps occupancy at STAGES.
//  - out_ovf and out_zero are computed in the last stage from the final carries and sum.
//  - Wrap-around: 0xFF..F + 1 gives sum 0, cout=1, zero=1, ovf=0.
//  - Reset mid-operation discards all in-flight beats immediately. No partial result is emitted.
//  - Outputs are stable while out_valid & !out_ready.
// STRUCTURE
//  - Shared header cla_defs.vh holds GROUP_W=4 and `define macros for the segment width and the legality check.
//    The legality check is WIDTH % (4*STAGES) == 0, enforced in an initial block with $error.
//  - One sub-module, cla_segment #(SEG): combinational SEG-bit CLA built from 4-bit groups with group G/P
//    and 2-level lookahead. Ports a, b, cin -> sum, cout, c_msb (carry into MSB). It is instantiated STAGES times via generate.
//  - Top level holds only the pipeline registers, valid/advance logic, operand skew registers and flags.
// TESTING
//  1. Reset, then WIDTH=64/STAGES=4. Drive A=0, B=0xFFFF_FFFF_FFFF_FFFF, cin=1.
//     Expect sum=0, cout=1, zero=1, ovf=0, and out_valid exactly 4 cycles after acceptance.
//  2. Subtraction: A=5, B=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
//     Then A=0x8000_0000_0000_0000, B=1, sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
//  3. Back-to-back stream of 100 random beats with out_ready=1. Expect one result per cycle, in order,
//     each matching a 65-bit reference model, and in_ready constantly 1.
//  4. Back-pressure: out_ready=0 for 10 cycles during a stream. After 4 accepts, in_ready=0 and out_sum is held stable.
//     Randomly toggle out_ready afterwards. Expect no loss or duplication (scoreboard).
//  5. Assert rst with 3 beats in flight. Expect out_valid=0 and all outputs 0 immediately.
//     After release, a new beat A=1, B=1 yields sum=2 with normal latency.
//  6. Parameter sweep (WIDTH,STAGES) = (16,1), (32,2), (128,8) with carry-ripple-through-every-segment vectors:
//     A=all ones, B=1. Expect correct sum=0, cout=1.

Source files
------------

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   GROUP_W      : width of one lookahead group inside a segment
//   CLA_SEG_W    : segment width for a given (WIDTH, STAGES)
//   CLA_LEGAL    : WIDTH must split into STAGES segments made of whole groups
//   cla_flags_t  : result flags produced by the last pipeline stage
`ifndef CLA_DEFS_SVH
`define CLA_DEFS_SVH
`define CLA_SEG_W(w, s) ((w) / (s))
`define CLA_LEGAL(w, s) (((s) >= 1) && (((w) % (4 * (s))) == 0))
`endif

package pipelined_cla_adder_pkg;
  localparam int GROUP_W = 4;

  typedef struct packed {
    logic ovf;
    logic zero;
  } cla_flags_t;
endpackage

// File: rtl/pipelined_cla_adder_cla_segment.sv
// cla_segment: combinational SEG-bit carry-lookahead adder.
// Built from 4-bit groups, each producing group generate/propagate,
// with a second lookahead level computing every group carry-in directly.
//   a, b   : SEG-bit operands (b already inverted by the caller for subtract)
//   cin    : carry into bit 0
//   sum    : SEG-bit sum
//   cout   : carry out of bit SEG-1
//   c_msb  : carry into bit SEG-1 (used for signed overflow)
module cla_segment
  import pipelined_cla_adder_pkg::*;
#(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb
);
  localparam int NG = SEG / GROUP_W;

  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [NG:0]   grp_c;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      logic [GROUP_W-1:0] g;
      logic [GROUP_W-1:0] p;
      logic [GROUP_W-1:0] c;

      assign g = a[gi*GROUP_W +: GROUP_W] & b[gi*GROUP_W +: GROUP_W];
      assign p = a[gi*GROUP_W +: GROUP_W] ^ b[gi*GROUP_W +: GROUP_W];

      // Bit carries inside the group, fully expanded from the group carry-in.
      assign c[0] = grp_c[gi];
      assign c[1] = g[0] | (p[0] & c[0]);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c[0]);

      assign grp_g[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                       | (p[3] & p[2] & p[1] & g[0]);
      assign grp_p[gi] = &p;

      assign sum[gi*GROUP_W +: GROUP_W] = p ^ c;
    end
  endgenerate

  // Second lookahead level: carry into group j+1 is the OR over t<=j of
  // G[t] gated by the propagates above it, plus cin gated by all of them.
  always_comb begin
    logic acc;
    logic pp;
    grp_c    = '0;
    grp_c[0] = cin;
    for (int j = 0; j < NG; j++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int t = j; t >= 0; t--) begin
        acc = acc | (pp & grp_g[t]);
        pp  = pp & grp_p[t];
      end
      grp_c[j+1] = acc | (pp & cin);
    end
  end

  assign cout  = grp_c[NG];
  assign c_msb = g_grp[NG-1].c[GROUP_W-1];
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit adder/subtractor split into STAGES segments,
// one segment added per pipeline stage with the carry registered in between.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : operand handshake (in_a, in_b, in_cin, in_sub)
//   out_valid/out_ready   : result handshake
//   out_sum, out_cout     : result mod 2^WIDTH and carry out (subtract: 1 = no borrow)
//   out_ovf, out_zero     : signed overflow and zero-result flags
// Stage k stores its valid bit, the carry out of segment k, the low sum bits
// accumulated so far and the operand bits not yet consumed.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int SEG = `CLA_SEG_W(WIDTH, STAGES);

  if (!`CLA_LEGAL(WIDTH, STAGES)) begin : g_illegal
    $error("pipelined_cla_adder: WIDTH must be a multiple of 4*STAGES");
  end

  cla_flags_t flags_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic                  valid_reg;
      logic                  carry_reg;
      logic [(gi+1)*SEG-1:0] sum_reg;
      logic                  load;
      logic                  src_valid;
      logic                  src_sub;
      logic                  src_cin;
      logic [SEG-1:0]        seg_a;
      logic [SEG-1:0]        seg_b;
      logic [SEG-1:0]        seg_sum;
      logic [(gi+1)*SEG-1:0] sum_in;
      logic                  seg_cout;
      logic                  seg_cmsb;

      if (gi == 0) begin : g_src
        assign src_valid = in_valid;
        assign src_sub   = in_sub;
        // Subtract forces carry-in to 1 (two's complement of B).
        assign src_cin   = in_sub | in_cin;
        assign seg_a     = in_a[SEG-1:0];
        assign seg_b     = in_b[SEG-1:0];
        assign sum_in    = seg_sum;
      end else begin : g_src
        assign src_valid = g_stage[gi-1].valid_reg;
        assign src_sub   = g_stage[gi-1].g_rem.sub_reg;
        assign src_cin   = g_stage[gi-1].carry_reg;
        assign seg_a     = g_stage[gi-1].g_rem.a_rem_reg[SEG-1:0];
        assign seg_b     = g_stage[gi-1].g_rem.b_rem_reg[SEG-1:0];
        assign sum_in    = {seg_sum, g_stage[gi-1].sum_reg};
      end

      cla_segment #(.SEG(SEG)) u_seg (
        .a    (seg_a),
        .b    (seg_b ^ {SEG{src_sub}}),
        .cin  (src_cin),
        .sum  (seg_sum),
        .cout (seg_cout),
        .c_msb(seg_cmsb)
      );

      // A stage may take new contents when it is empty or its contents leave;
      // this chain runs combinationally from out_ready back to in_ready.
      if (gi == STAGES - 1) begin : g_load
        assign load = !valid_reg | out_ready;
      end else begin : g_load
        assign load = !valid_reg | g_stage[gi+1].load;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          sum_reg   <= '0;
        end else if (load) begin
          valid_reg <= src_valid;
          if (src_valid) begin
            carry_reg <= seg_cout;
            sum_reg   <= sum_in;
          end
        end
      end

      if (gi < STAGES - 1) begin : g_rem
        localparam int REM_W = WIDTH - (gi + 1) * SEG;
        logic [REM_W-1:0] a_rem_reg;
        logic [REM_W-1:0] b_rem_reg;
        logic [REM_W-1:0] a_rem_in;
        logic [REM_W-1:0] b_rem_in;
        logic             sub_reg;
        logic             unused_cmsb;

        // Only the final segment's carry-into-MSB matters for overflow.
        assign unused_cmsb = seg_cmsb;

        if (gi == 0) begin : g_in
          assign a_rem_in = in_a[WIDTH-1:SEG];
          assign b_rem_in = in_b[WIDTH-1:SEG];
        end else begin : g_in
          assign a_rem_in = g_stage[gi-1].g_rem.a_rem_reg[REM_W+SEG-1:SEG];
          assign b_rem_in = g_stage[gi-1].g_rem.b_rem_reg[REM_W+SEG-1:SEG];
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            a_rem_reg <= '0;
            b_rem_reg <= '0;
            sub_reg   <= 1'b0;
          end else if (load && src_valid) begin
            a_rem_reg <= a_rem_in;
            b_rem_reg <= b_rem_in;
            sub_reg   <= src_sub;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            flags_reg.ovf  <= 1'b0;
            flags_reg.zero <= 1'b0;
          end else if (load && src_valid) begin
            flags_reg.ovf  <= seg_cout ^ seg_cmsb;
            flags_reg.zero <= (sum_in == '0);
          end
        end
      end
    end
  endgenerate

  assign in_ready  = g_stage[0].load;
  assign out_valid = g_stage[STAGES-1].valid_reg;
  assign out_sum   = g_stage[STAGES-1].sum_reg;
  assign out_cout  = g_stage[STAGES-1].carry_reg;
  assign out_ovf   = flags_reg.ovf;
  assign out_zero  = flags_reg.zero;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;
  localparam int W = 64;
  localparam int S = 4;
  localparam int SW_W [3] = '{16, 32, 128};
  localparam int SW_S [3] = '{1, 2, 8};

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_cin, in_sub;
  logic         out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [W-1:0] in_a, in_b, out_sum;

  logic         sw_valid, sw_ready, sw_cin, sw_sub;
  logic [127:0] sw_a, sw_b;
  logic [2:0]   sw_in_ready, sw_out_valid, sw_cout, sw_ovf, sw_zero;
  logic [127:0] sw_sum [3];

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];
  logic chk_ready_on = 1'b0;
  logic rand_ready   = 1'b0;

  initial forever #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  for (genvar gi = 0; gi < 3; gi++) begin : g_sw
    localparam int WW = SW_W[gi];
    logic [WW-1:0] s;
    pipelined_cla_adder #(.WIDTH(WW), .STAGES(SW_S[gi])) u_sw (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_in_ready[gi]),
      .in_a(sw_a[WW-1:0]), .in_b(sw_b[WW-1:0]), .in_cin(sw_cin), .in_sub(sw_sub),
      .out_valid(sw_out_valid[gi]), .out_ready(sw_ready), .out_sum(s),
      .out_cout(sw_cout[gi]), .out_ovf(sw_ovf[gi]), .out_zero(sw_zero[gi])
    );
    assign sw_sum[gi] = 128'(s);
  end

  // Reference: plain 65-bit arithmetic; overflow from operand/result signs.
  function automatic exp_t model(logic [63:0] a, logic [63:0] b, logic cin, logic sub);
    exp_t        e;
    logic [63:0] bb;
    logic [64:0] full;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + 65'(sub ? 1'b1 : cin);
    e.sum  = full[63:0];
    e.cout = full[64];
    e.ovf  = (a[63] == bb[63]) && (full[63] != a[63]);
    e.zero = (full[63:0] == 64'd0);
    return e;
  endfunction

  function automatic logic [127:0] ones_of(int w);
    logic [127:0] one;
    one = 128'd1;
    return (w >= 128) ? '1 : ((one << w) - 128'd1);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
    logic acc;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    for (int t = 0; t < 200; t++) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        in_valid = 1'b0;
        $display("send a=0x%0h b=0x%0h cin=%0b sub=%0b", a, b, cin, sub);
        return;
      end
    end
    in_valid = 1'b0;
    fail_now("send_timeout");
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    for (int t = 0; t < 50 && !out_valid; t++) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) fail_now("wait_out_timeout");
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (q.size() == 0 && !out_valid) return;
      @(posedge clk); #1;
    end
    fail_now("drain_timeout");
  endtask

  // Scoreboard / compare process, sampled mid-cycle ahead of the next edge.
  logic [63:0] prev_sum;
  logic [2:0]  prev_flags;
  logic        hold_prev;
  initial begin
    exp_t e;
    hold_prev = 1'b0;
    prev_sum = '0;
    prev_flags = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_sum", out_sum, prev_sum);
          chk("hold_flags", {out_cout, out_ovf, out_zero}, prev_flags);
        end
        if (chk_ready_on) chk("stream_in_ready", in_ready, 1);
        if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_cin, in_sub));
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            e = q.pop_front();
            chk("sb_sum", out_sum, e.sum);
            chk("sb_cout", out_cout, e.cout);
            chk("sb_ovf", out_ovf, e.ovf);
            chk("sb_zero", out_zero, e.zero);
            $display("result sum=0x%0h cout=%0b ovf=%0b zero=%0b", out_sum, out_cout, out_ovf, out_zero);
          end
        end
        hold_prev  = out_valid && !out_ready;
        prev_sum   = out_sum;
        prev_flags = {out_cout, out_ovf, out_zero};
      end
    end
  end

  logic [63:0] ba [40];
  logic [63:0] bb [40];
  logic        bc [40];
  logic        bs [40];

  initial begin
    int   lat;
    int   n_acc;
    int   idx;
    logic acc;
    logic [2:0] seen;
    exp_t e;

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b1;
    sw_valid = 1'b0; sw_ready = 1'b1; sw_cin = 1'b0; sw_sub = 1'b0; sw_a = '0; sw_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_flags", {out_cout, out_ovf, out_zero}, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Pin the reference model to hand-computed values.
    e = model(64'd5, 64'd7, 1'b0, 1'b1);
    chk("model_sub_sum", e.sum, 64'hFFFF_FFFF_FFFF_FFFE);
    e = model(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    chk("model_sub_ovf", {e.cout, e.ovf}, 2'b11);

    // 1: wrap-around and latency
    send(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    wait_out(lat);
    chk("t1_latency", lat, 4);
    chk("t1_sum", out_sum, 0);
    chk("t1_flags", {out_cout, out_zero, out_ovf}, 3'b110);

    // 2: subtraction
    send(64'd5, 64'd7, 1'b0, 1'b1);
    wait_out(lat);
    chk("t2a_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t2a_cout_ovf", {out_cout, out_ovf}, 2'b00);
    send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    wait_out(lat);
    chk("t2b_sum", out_sum, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("t2b_ovf", out_ovf, 1);
    drain();

    // 3: back-to-back random stream
    chk_ready_on = 1'b1;
    for (int i = 0; i < 100; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk_ready_on = 1'b0;
    drain();

    // 4: back-pressure then random out_ready
    for (int i = 0; i < 40; i++) begin
      ba[i] = {$urandom, $urandom}; bb[i] = {$urandom, $urandom};
      bc[i] = 1'($urandom_range(0, 1)); bs[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b0;
    n_acc = 0;
    idx = 0;
    in_valid = 1'b1; in_a = ba[0]; in_b = bb[0]; in_cin = bc[0]; in_sub = bs[0];
    for (int c = 0; c < 10; c++) begin
      #1;
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        n_acc++;
        idx++;
        in_a = ba[idx]; in_b = bb[idx]; in_cin = bc[idx]; in_sub = bs[idx];
      end
    end
    #1;
    chk("t4_accepts", n_acc, 4);
    chk("t4_full_in_ready", in_ready, 0);
    e = model(ba[0], bb[0], bc[0], bs[0]);
    chk("t4_held_sum", out_sum, e.sum);
    out_ready = 1'b1;
    #1;
    chk("t4_ready_rise", in_ready, 1);
    rand_ready = 1'b1;
    while (idx < 40) begin
      send(ba[idx], bb[idx], bc[idx], bs[idx]);
      idx++;
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    // 5: reset with beats in flight
    out_ready = 1'b0;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0);
    send(64'd10, 64'd20, 1'b1, 1'b0);
    send(64'd100, 64'd3, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("t5_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_sum", out_sum, 0);
    chk("t5_rst_flags", {out_cout, out_ovf, out_zero}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(64'd1, 64'd1, 1'b0, 1'b0);
    wait_out(lat);
    chk("t5_latency", lat, 4);
    chk("t5_sum", out_sum, 2);
    drain();

    // 6: parameter sweep, carry/borrow rippling through every segment
    for (int v = 0; v < 2; v++) begin
      sw_a = (v == 0) ? '1 : '0;
      sw_b = 128'd1;
      sw_sub = (v == 1);
      sw_cin = 1'b0;
      sw_valid = 1'b1;
      #1;
      chk("sw_in_ready", sw_in_ready, 3'b111);
      @(posedge clk); #1;
      sw_valid = 1'b0;
      seen = '0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
        for (int i = 0; i < 3; i++) begin
          if (sw_out_valid[i] && !seen[i]) begin
            seen[i] = 1'b1;
            $display("sweep W=%0d v=%0d sum=0x%0h cout=%0b", SW_W[i], v, sw_sum[i], sw_cout[i]);
            chk($sformatf("sw%0d_latency", SW_W[i]), cyc, SW_S[i]);
            chk($sformatf("sw%0d_sum", SW_W[i]), sw_sum[i], (v == 0) ? 128'd0 : ones_of(SW_W[i]));
            chk($sformatf("sw%0d_cout", SW_W[i]), sw_cout[i], (v == 0));
            chk($sformatf("sw%0d_ovf", SW_W[i]), sw_ovf[i], 0);
            chk($sformatf("sw%0d_zero", SW_W[i]), sw_zero[i], (v == 0));
          end
        end
        @(posedge clk); #1;
      end
      chk("sw_seen", seen, 3'b111);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
